// File: rtl/e_multi_prio_gen.sv
// e_multi_prio_gen
//   Round-robin priority generator and grant tracker at the control end of
//   the e_multi_cell priority chain. Presents vld/prior/sel to the chain,
//   captures the one-hot grant that comes back, holds it until the winner
//   acknowledges (or withdraws), then rotates priority past the winner.
//
//   Optional build macro: E_MULTI_PRIO_GEN_LOCK_EN adds lock_i; an ack with
//   lock_i=1 keeps the grant (multi-beat ownership).
//
// Ports
//   clk        clock
//   arst       asynchronous active-high reset
//   req_i      level requests, one bit per requester
//   gnt_vld_i  chain result valid
//   gnt_i      one-hot grant from the chain
//   ack_i      granted requester consumed its grant
//   lock_i     (LOCK_EN build only) keep ownership on ack
//   vld_o      arbitration request to the chain
//   prior_o    chain carry-in
//   sel_o      one-hot highest-priority position
//   gnt_o      held grant, one-hot or zero
//   err_o      sticky protocol-error flag
//
// state | meaning
// IDLE  | no pending requests
// ARB   | chain asked to arbitrate, waiting for gnt_vld_i
// GRANT | grant held until ack or withdrawal
module e_multi_prio_gen #(
  parameter int RADIX_N = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [RADIX_N-1:0] req_i,
  input  logic               gnt_vld_i,
  input  logic [RADIX_N-1:0] gnt_i,
  input  logic               ack_i,
`ifdef E_MULTI_PRIO_GEN_LOCK_EN
  input  logic               lock_i,
`endif
  output logic               vld_o,
  output logic               prior_o,
  output logic [RADIX_N-1:0] sel_o,
  output logic [RADIX_N-1:0] gnt_o,
  output logic               err_o
);

  localparam int PW = (RADIX_N > 1) ? $clog2(RADIX_N) : 1;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [RADIX_N-1:0] sel_r, sel_nxt;
  logic [RADIX_N-1:0] gnt_r, gnt_nxt;
  logic               err_r, err_nxt;
  logic [PW-1:0]      gidx, gidx_inc;
  logic               gnt_onehot, gnt_ok, held_req, locked, release_ack;

`ifdef E_MULTI_PRIO_GEN_LOCK_EN
  assign locked = lock_i;
`else
  assign locked = 1'b0;
`endif

  assign release_ack = ack_i & ~locked;
  assign held_req    = |(req_i & gnt_r);

  // zero and multi-hot both fail this test
  assign gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - RADIX_N'(1))) == '0);
  assign gnt_ok     = gnt_onehot && (|(gnt_i & req_i));

  always_comb begin
    gidx = '0;
    for (int i = 0; i < RADIX_N; i++) begin
      if (gnt_r[i]) gidx = PW'(i);
    end
  end

  // wrap explicitly: RADIX_N need not be a power of two
  assign gidx_inc = (gidx == PW'(RADIX_N - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_r;
    err_nxt   = err_r;
    case (state)
      IDLE: begin
        if (|req_i) state_nxt = ARB;
      end
      ARB: begin
        if (gnt_vld_i) begin
          if (gnt_ok) begin
            gnt_nxt   = gnt_i;
            state_nxt = GRANT;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (!(|req_i)) begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        // ack takes precedence over a same-cycle withdrawal
        if (release_ack) begin
          ptr_nxt   = gidx_inc;
          gnt_nxt   = '0;
          state_nxt = (|(req_i & ~gnt_r)) ? ARB : IDLE;
        end else if (!held_req) begin
          gnt_nxt   = '0;
          state_nxt = (|req_i) ? ARB : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    sel_nxt = RADIX_N'(1) << ptr_nxt;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      ptr   <= '0;
      sel_r <= RADIX_N'(1);
      gnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel_r <= sel_nxt;
      gnt_r <= gnt_nxt;
      err_r <= err_nxt;
    end
  end

  assign vld_o   = (state == ARB);
  assign prior_o = (state == ARB);
  assign sel_o   = sel_r;
  assign gnt_o   = gnt_r;
  assign err_o   = err_r;

endmodule
